// File: rtl/serial_adder_if.sv
// Handshake and data bundle for serial_adder.
// The optional sub signal is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add the sub input (a - b via ~b and carry-in of 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             s_bit, c_next;

  // Operand conditioning at accept: subtract is a + ~b + 1.
  always_comb begin
    b_load = bus.b;
    c_load = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_load = ~bus.b;
      c_load = 1'b1;
    end
`endif
  end

  // Full-adder cell, next-state and completion logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    s_bit   = a_q[0] ^ b_q[0] ^ c_q;
    c_next  = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_load;
          c_d     = c_load;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Shift form keeps WIDTH=1 legal (no zero-width slices).
        r_d   = (r_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = r_d;
          cout_d  = c_next;
          // c_q is the carry into the MSB on the final bit.
          ovf_d   = c_q ^ c_next;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8; subtract vectors run when SERIAL_ADDER_SUB_EN is set.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  serial_adder_if #(.WIDTH(8)) bus ();

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
  endtask

  // Drive start for one edge (T0) and confirm acceptance.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub);
    @(negedge clk);
    set_ops(a, b, cin, sub);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq("busy_t0", 32'(bus.busy), 32'd1);
  endtask

  // Edges T1..T8 then T9; busy held through T7, one-cycle done at T8.
  task automatic finish_op(input string tag, input logic [7:0] esum, input logic ecout,
                           input logic eovf);
    int busy_ok = 1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_ok = 0;
    end
    check_eq({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
    check_eq({tag, "_busy_t8"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    check_eq({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(eovf));
    @(posedge clk);
    #1;
    check_eq({tag, "_done_fall"}, 32'(bus.done), 32'd0);
    check_eq({tag, "_sum_hold"}, 32'(bus.sum), 32'(esum));
  endtask

  initial begin
    bus.start = 1'b0;
    set_ops(8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_sum", 32'(bus.sum), 32'd0);
    check_eq("rst_cout", 32'(bus.cout), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    finish_op("simple", 8'h10, 1'b0, 1'b0);
    start_op(8'hFF, 8'h00, 1'b1, 1'b0);
    finish_op("wrap", 8'h00, 1'b1, 1'b0);
    start_op(8'h7F, 8'h01, 1'b0, 1'b0);
    finish_op("sovf", 8'h80, 1'b0, 1'b1);

    // Ignored start at T3, then start held through done.
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    set_ops(8'h11, 8'h01, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 4; i <= 7; i++) @(posedge clk);
    @(negedge clk);
    set_ops(8'h02, 8'h03, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ign_done_t8", 32'(bus.done), 32'd1);
    check_eq("ign_sum_t8", 32'(bus.sum), 32'h10);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq("b2b_busy_t9", 32'(bus.busy), 32'd1);
    check_eq("b2b_done_t9", 32'(bus.done), 32'd0);
    check_eq("b2b_sum_t9", 32'(bus.sum), 32'h10);
    finish_op("b2b", 8'h05, 1'b0, 1'b0);

    // Asynchronous reset between T4 and T5.
    start_op(8'h33, 8'h44, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", 32'(bus.busy), 32'd0);
    check_eq("mrst_done", 32'(bus.done), 32'd0);
    check_eq("mrst_sum", 32'(bus.sum), 32'd0);
    check_eq("mrst_cout", 32'(bus.cout), 32'd0);
    check_eq("mrst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(8'h20, 8'h22, 1'b0, 1'b0);
    finish_op("post_rst", 8'h42, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    start_op(8'h05, 8'h07, 1'b1, 1'b1);
    finish_op("sub_neg", 8'hFE, 1'b0, 1'b0);
    start_op(8'h80, 8'h01, 1'b0, 1'b1);
    finish_op("sub_ovf", 8'h7F, 1'b1, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
